// File: rtl/toy_bpu_ghr_ckpt_if.sv
// Port bundle for the GHR checkpoint queue: allocation, commit and restore
// requests towards the queue, plus the repaired GHR and occupancy back out.
interface toy_bpu_ghr_ckpt_if #(
  parameter int GHR_W = 64,
  parameter int DEPTH = 8,
  parameter int ID_W  = $clog2(DEPTH)
);
  logic             flush_all;
  logic             alloc_vld;
  logic [GHR_W-1:0] alloc_ghr;
  logic             alloc_rdy;
  logic [ID_W-1:0]  alloc_id;
  logic             cmt_vld;
  logic             rsto_vld;
  logic [ID_W-1:0]  rsto_id;
  logic             rsto_taken;
  logic             ghr_rsto_vld;
  logic [GHR_W-1:0] ghr_rsto_val;
  logic [ID_W:0]    ckpt_cnt;

  modport master (
    output flush_all, alloc_vld, alloc_ghr, cmt_vld, rsto_vld, rsto_id, rsto_taken,
    input  alloc_rdy, alloc_id, ghr_rsto_vld, ghr_rsto_val, ckpt_cnt
  );

  modport slave (
    input  flush_all, alloc_vld, alloc_ghr, cmt_vld, rsto_vld, rsto_id, rsto_taken,
    output alloc_rdy, alloc_id, ghr_rsto_vld, ghr_rsto_val, ckpt_cnt
  );
endinterface

// File: rtl/toy_bpu_ghr_ckpt.sv
// Circular queue of global-history snapshots taken at each predicted branch;
// a mispredict rewinds the queue to that branch and emits the repaired GHR.
module toy_bpu_ghr_ckpt #(
  parameter int GHR_W = 64,
  parameter int DEPTH = 8,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  toy_bpu_ghr_ckpt_if.slave  bus
);
  localparam int PTR_W = ID_W + 1;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] head_nxt_s;
  logic [PTR_W-1:0] tail_nxt_s;
  logic [GHR_W-1:0] ckpt_r [DEPTH];

  logic [ID_W-1:0]  head_idx_s;
  logic [ID_W-1:0]  tail_idx_s;
  logic [ID_W-1:0]  rsto_dist_s;
  logic [GHR_W-1:0] rsto_snap_s;
  logic             empty_s;
  logic             full_s;
  logic             alloc_fire_s;
  logic             cmt_fire_s;
  logic             rsto_fire_s;

  logic             rsto_vld_r;
  logic [GHR_W-1:0] rsto_val_r;

  assign head_idx_s = head_r[ID_W-1:0];
  assign tail_idx_s = tail_r[ID_W-1:0];
  assign empty_s    = (head_r == tail_r);
  assign full_s     = (head_idx_s == tail_idx_s) && (head_r[ID_W] != tail_r[ID_W]);

  // flush_all dominates everything; restore then blocks allocation
  assign rsto_fire_s  = bus.rsto_vld & ~bus.flush_all;
  assign cmt_fire_s   = bus.cmt_vld & ~empty_s & ~bus.flush_all;
  assign alloc_fire_s = bus.alloc_vld & ~full_s & ~bus.rsto_vld & ~bus.flush_all;

  // Distance from the oldest live entry wraps naturally in ID_W bits
  assign rsto_dist_s = bus.rsto_id - head_idx_s;
  assign rsto_snap_s = ckpt_r[bus.rsto_id];

  // Next-state pointers; the restore tail is based on the pre-commit head
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    if (bus.flush_all) begin
      tail_nxt_s = head_r;
    end else begin
      if (cmt_fire_s) begin
        head_nxt_s = head_r + PTR_W'(1);
      end else begin
        head_nxt_s = head_r;
      end
      if (rsto_fire_s) begin
        tail_nxt_s = head_r + {1'b0, rsto_dist_s} + PTR_W'(1);
      end else if (alloc_fire_s) begin
        tail_nxt_s = tail_r + PTR_W'(1);
      end else begin
        tail_nxt_s = tail_r;
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
    end
  end

  // Snapshot storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      ckpt_r[tail_idx_s] <= bus.alloc_ghr;
    end
  end

  // Repaired GHR: the snapshot shifted by the branch's resolved direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsto_vld_r <= 1'b0;
      rsto_val_r <= '0;
    end else begin
      rsto_vld_r <= rsto_fire_s;
      if (rsto_fire_s) begin
        rsto_val_r <= {rsto_snap_s[GHR_W-2:0], bus.rsto_taken};
      end
    end
  end

  assign bus.alloc_rdy    = ~full_s;
  assign bus.alloc_id     = tail_idx_s;
  assign bus.ckpt_cnt     = tail_r - head_r;
  assign bus.ghr_rsto_vld = rsto_vld_r;
  assign bus.ghr_rsto_val = rsto_val_r;
endmodule

// File: tb/tb_toy_bpu_ghr_ckpt.sv
// Directed table-driven bench for toy_bpu_ghr_ckpt at GHR_W=8, DEPTH=4.
module tb_toy_bpu_ghr_ckpt;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  toy_bpu_ghr_ckpt_if #(.GHR_W(8), .DEPTH(4)) bus ();

  toy_bpu_ghr_ckpt #(.GHR_W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       flush;
    logic       av;
    logic [7:0] ag;
    logic       cm;
    logic       rv;
    logic [1:0] rid;
    logic       rt;
    logic       e_rdy;
    logic [1:0] e_id;
    logic [2:0] e_cnt;
    logic       e_rvld;
    logic [7:0] e_rval;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic fl, input logic av, input logic [7:0] ag,
                              input logic cm, input logic rv, input logic [1:0] rid,
                              input logic rt, input logic e_rdy, input logic [1:0] e_id,
                              input logic [2:0] e_cnt, input logic e_rvld,
                              input logic [7:0] e_rval);
    vec_t v;
    v.flush = fl; v.av = av; v.ag = ag; v.cm = cm; v.rv = rv; v.rid = rid; v.rt = rt;
    v.e_rdy = e_rdy; v.e_id = e_id; v.e_cnt = e_cnt; v.e_rvld = e_rvld; v.e_rval = e_rval;
    return v;
  endfunction

  task automatic drive_idle();
    bus.flush_all  = 1'b0;
    bus.alloc_vld  = 1'b0;
    bus.alloc_ghr  = 8'h00;
    bus.cmt_vld    = 1'b0;
    bus.rsto_vld   = 1'b0;
    bus.rsto_id    = 2'd0;
    bus.rsto_taken = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic rdy, input logic [1:0] id,
                             input logic [2:0] cnt, input logic rvld);
    chk({tag, " rdy"},  32'(bus.alloc_rdy),    32'(rdy));
    chk({tag, " id"},   32'(bus.alloc_id),     32'(id));
    chk({tag, " cnt"},  32'(bus.ckpt_cnt),     32'(cnt));
    chk({tag, " rvld"}, 32'(bus.ghr_rsto_vld), 32'(rvld));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    drive_idle();
    rst = 1'b1;

    // Post-edge expectations: {fl,av,ag,cm,rv,rid,rt, rdy,id,cnt,rvld,rval}
    // Fill then drop a fifth allocation
    vecs.push_back(mk(1'b0,1'b1,8'h11,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd1,3'd1,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h22,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h33,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd3,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h44,1'b0,1'b0,2'd0,1'b0, 1'b0,2'd0,3'd4,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h55,1'b0,1'b0,2'd0,1'b0, 1'b0,2'd0,3'd4,1'b0,8'h00));
    // Restore id 1 taken: {0x22[6:0],1} = 0x45
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,2'd1,1'b1, 1'b1,2'd2,3'd2,1'b1,8'h45));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd0,1'b0,8'h00));
    // Wrap: 4 allocs, 3 commits, 2 allocs, restore id 0 not-taken
    vecs.push_back(mk(1'b0,1'b1,8'hA0,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd1,3'd1,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hA1,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hA2,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd3,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hA3,1'b0,1'b0,2'd0,1'b0, 1'b0,2'd0,3'd4,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd1,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hB0,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd1,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hB1,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,2'd0,1'b0, 1'b1,2'd1,3'd2,1'b1,8'h60));
    // Refill to full (head idx 3), then restore+commit+alloc together
    vecs.push_back(mk(1'b0,1'b1,8'hC1,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hC2,1'b0,1'b0,2'd0,1'b0, 1'b0,2'd3,3'd4,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'hEE,1'b1,1'b1,2'd1,1'b1, 1'b1,2'd2,3'd2,1'b1,8'h83));
    // Flush beats restore, commit and alloc; commit on empty is ignored
    vecs.push_back(mk(1'b0,1'b1,8'hD0,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd3,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b1,8'hD1,1'b1,1'b1,2'd0,1'b1, 1'b1,2'd0,3'd0,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd0,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b1,1'b0,2'd0,1'b0, 1'b1,2'd0,3'd0,1'b0,8'h00));
    // Back-to-back restores, each with its own pulse
    vecs.push_back(mk(1'b0,1'b1,8'h10,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd1,3'd1,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h20,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd2,3'd2,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b1,8'h30,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd3,3'd3,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,2'd2,1'b0, 1'b1,2'd3,3'd3,1'b1,8'h60));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,2'd0,1'b1, 1'b1,2'd1,3'd1,1'b1,8'h21));
    vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0,2'd0,1'b0, 1'b1,2'd1,3'd1,1'b0,8'h00));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1'b1, 2'd0, 3'd0, 1'b0);
    chk("reset rval", 32'(bus.ghr_rsto_val), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.flush_all  = vecs[i].flush;
      bus.alloc_vld  = vecs[i].av;
      bus.alloc_ghr  = vecs[i].ag;
      bus.cmt_vld    = vecs[i].cm;
      bus.rsto_vld   = vecs[i].rv;
      bus.rsto_id    = vecs[i].rid;
      bus.rsto_taken = vecs[i].rt;
      @(posedge clk);
      #1;
      check_state($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_id, vecs[i].e_cnt,
                  vecs[i].e_rvld);
      if (vecs[i].e_rvld)
        chk($sformatf("row%0d rval", i), 32'(bus.ghr_rsto_val), 32'(vecs[i].e_rval));
    end

    // Reset lands between a restore request and its pulse edge
    bus.flush_all = 1'b0; bus.alloc_vld = 1'b0; bus.cmt_vld = 1'b0;
    bus.rsto_vld  = 1'b1; bus.rsto_id   = 2'd0; bus.rsto_taken = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("midrst async cnt", 32'(bus.ckpt_cnt), 32'd0);
    @(posedge clk);
    #1;
    check_state("midrst", 1'b1, 2'd0, 3'd0, 1'b0);
    drive_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("after_rst", 1'b1, 2'd0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/toy_bpu_ghr_ckpt.md
TOY_BPU_GHR_CKPT -- requirements
Module: toy_bpu_ghr_ckpt

Interface
REQ-001 SHALL have parameter GHR_W, default 64: width of one GHR snapshot.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two, >=2): number of checkpoint entries.
REQ-003 SHALL have parameter ID_W, default $clog2(DEPTH): checkpoint id width.
REQ-004 SHALL have port clk  in  1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-006 SHALL have port flush_all  in  1: backend flush; discard all checkpoints.
REQ-007 SHALL have port alloc_vld  in  1: predicted branch requests a checkpoint.
REQ-008 SHALL have port alloc_ghr  in  GHR_W: GHR value to snapshot, taken before the branch's own shift.
REQ-009 SHALL have port alloc_rdy  out  1: a free entry exists.
REQ-010 SHALL have port alloc_id  out  ID_W: id granted to the current allocation (tail index).
REQ-011 SHALL have port cmt_vld  in  1: oldest branch retired; release the head entry.
REQ-012 SHALL have port rsto_vld  in  1: mispredict on a checkpointed branch.
REQ-013 SHALL have port rsto_id  in  ID_W: checkpoint id of the mispredicted branch.
REQ-014 SHALL have port rsto_taken  in  1: resolved direction of that branch.
REQ-015 SHALL have port ghr_rsto_vld  out  1: one-cycle pulse; load ghr_rsto_val into the GHR.
REQ-016 SHALL have port ghr_rsto_val  out  GHR_W: the repaired GHR value.
REQ-017 SHALL have port ckpt_cnt  out  ID_W+1: number of live entries.

Function
REQ-018 SHALL keep head and tail pointers, each ID_W+1 bits wide (index plus wrap bit); ckpt_cnt = tail - head, taken modulo 2^(ID_W+1).
REQ-019 SHALL define empty as head==tail and full as equal indices with differing wrap bits; alloc_rdy = ~full (registered state only, never combinational on cmt_vld).
REQ-020 SHALL drive alloc_id = tail index combinationally.
REQ-021 An allocation SHALL fire when alloc_vld & alloc_rdy & ~rsto_vld & ~flush_all; on firing it writes alloc_ghr to entry tail and increments tail.
REQ-022 alloc_vld while full SHALL be dropped, leaving storage and pointers unchanged.
REQ-023 cmt_vld while not empty SHALL increment head; cmt_vld while empty SHALL be ignored.
REQ-024 On rsto_vld, tail SHALL become head + ((rsto_id - head index) mod DEPTH) + 1, computed at full pointer width; this keeps entry rsto_id and squashes all younger entries.
REQ-025 On rsto_vld, the next cycle SHALL give ghr_rsto_vld=1 and ghr_rsto_val = {ckpt[rsto_id][GHR_W-2:0], rsto_taken} (latency 1, registered).
REQ-026 A commit in the same cycle as a restore SHALL still increment head; the restore tail calculation SHALL use the pre-commit head.
REQ-027 A restore with rsto_id outside the live range is illegal; behaviour is unspecified, but the block SHALL NOT deadlock (the next flush_all recovers it).
REQ-028 flush_all SHALL set tail=head (empty), suppress allocation, ignore rsto_vld, and produce no ghr_rsto_vld pulse; commit in the same cycle is ignored.
REQ-029 Priority SHALL be flush_all > rsto_vld > alloc_vld; cmt_vld is orthogonal except under flush_all.
REQ-030 Back-to-back restores on consecutive cycles SHALL each produce their own pulse, each using the state present in its own cycle.
REQ-031 Pointers SHALL wrap from index DEPTH-1 to 0 and toggle their wrap bit.
REQ-032 Checkpoint storage SHALL be plain flops with no reset requirement; only pointers and outputs are reset.

Reset
REQ-033 While rst=1: head=tail=0, alloc_rdy=1, alloc_id=0, ckpt_cnt=0, ghr_rsto_vld=0, ghr_rsto_val=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately and cancel any pending restore pulse.

Verification (GHR_W=8, DEPTH=4)
REQ-035 Fill: 4 allocs with ghr 0x11,0x22,0x33,0x44 -> alloc_id 0,1,2,3; ckpt_cnt=4; alloc_rdy=0; a 5th alloc is dropped with cnt still 4.
REQ-036 Restore: from the filled state, rsto_id=1, taken=1 -> next cycle ghr_rsto_vld=1, val=0x45; cnt=2; the next alloc_id is 2.
REQ-037 Wrap: 4 allocs, 3 commits, 2 allocs -> ids 0,1,2,3,0,1; cnt=3; rsto_id=0, taken=0 -> cnt=2.
REQ-038 Simultaneous events: full state plus rsto_id=2 plus cmt_vld plus alloc_vld in one cycle -> alloc dropped; cnt=2 (head=1, tail=3); pulse val = {ckpt[2][6:0],taken}.
REQ-039 Flush: 3 live entries plus flush_all plus rsto_vld -> cnt=0; no ghr_rsto_vld pulse; alloc_rdy=1.
REQ-040 Reset mid-restore: rsto_vld in cycle N and rst asserted before edge N+1 -> ghr_rsto_vld stays 0; cnt=0.
